// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 4-digit display scanner.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'hF;

  typedef logic [DIGIT_W-1:0] digit_t;
  // Packed so that field k lines up with data[4k+3:4k].
  typedef digit_t [NUM_DIGITS-1:0] digits_t;

  // Digit k (k >= 1) is a leading zero when it and every digit above it are 0.
  function automatic logic [NUM_DIGITS-1:0] lzb_mask(input digits_t d);
    logic zero_above;
    lzb_mask   = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above & (d[k] == '0);
      lzb_mask[k] = zero_above;
    end
  endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Free-running scan prescaler; tick is high for one cycle every 2^DIV_W cycles.
module disp_prescaler #(
  parameter int unsigned DIV_W = 17
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + {{(DIV_W - 1){1'b0}}, 1'b1};
  assign tick  = &cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_scan_mux.sv
// Four-digit display scan multiplexer with frame-synchronous (tear-free) updates.
// Define DISP_LZB_EN to enable automatic leading-zero blanking.
module disp_scan_mux
  import disp_pkg::*;
#(
  parameter int unsigned DIV_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [15:0]           data,
  input  logic [NUM_DIGITS-1:0] dp,
  input  logic [NUM_DIGITS-1:0] blank,
  output logic [DIGIT_W-1:0]    hex,
  output logic                  le,
  output logic                  pt,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  pending
);

  logic tick;

  disp_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [1:0]            idx_q, idx_d;
  digits_t               shd_data_q, shd_data_d, pnd_data_q, pnd_data_d;
  logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d, pnd_dp_q, pnd_dp_d;
  logic [NUM_DIGITS-1:0] shd_blank_q, shd_blank_d, pnd_blank_q, pnd_blank_d;
  logic                  pending_q, pending_d;
  logic [DIGIT_W-1:0]    hex_q, hex_d;
  logic                  le_q, le_d, pt_q, pt_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [NUM_DIGITS-1:0] auto_blank;
  logic                  frame_end;

  always_comb begin
    idx_d       = idx_q;
    shd_data_d  = shd_data_q;
    shd_dp_d    = shd_dp_q;
    shd_blank_d = shd_blank_q;
    pnd_data_d  = pnd_data_q;
    pnd_dp_d    = pnd_dp_q;
    pnd_blank_d = pnd_blank_q;
    pending_d   = pending_q;
    hex_d       = hex_q;
    le_d        = le_q;
    pt_d        = pt_q;
    an_d        = an_q;
    auto_blank  = '0;
    frame_end   = tick && (idx_q == 2'd3);

    if (frame_end) begin
      // A load landing on the boundary bypasses the pending stage.
      if (load) begin
        shd_data_d  = data;
        shd_dp_d    = dp;
        shd_blank_d = blank;
      end else if (pending_q) begin
        shd_data_d  = pnd_data_q;
        shd_dp_d    = pnd_dp_q;
        shd_blank_d = pnd_blank_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pnd_data_d  = data;
      pnd_dp_d    = dp;
      pnd_blank_d = blank;
      pending_d   = 1'b1;
    end

`ifdef DISP_LZB_EN
    auto_blank = lzb_mask(shd_data_d);
`else
    auto_blank = '0;
`endif

    // Outputs come from next-state shadow so digit 0 of a new frame is already fresh.
    if (tick) begin
      idx_d = idx_q + 2'd1;
      hex_d = shd_data_d[idx_d];
      pt_d  = shd_dp_d[idx_d];
      le_d  = shd_blank_d[idx_d] | auto_blank[idx_d];
      an_d  = ~(4'b0001 << idx_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= 2'd3;
      shd_data_q  <= '0;
      shd_dp_q    <= '0;
      shd_blank_q <= 4'hF;
      pnd_data_q  <= '0;
      pnd_dp_q    <= '0;
      pnd_blank_q <= '0;
      pending_q   <= 1'b0;
      hex_q       <= '0;
      le_q        <= 1'b1;
      pt_q        <= 1'b0;
      an_q        <= AN_OFF;
    end else begin
      idx_q       <= idx_d;
      shd_data_q  <= shd_data_d;
      shd_dp_q    <= shd_dp_d;
      shd_blank_q <= shd_blank_d;
      pnd_data_q  <= pnd_data_d;
      pnd_dp_q    <= pnd_dp_d;
      pnd_blank_q <= pnd_blank_d;
      pending_q   <= pending_d;
      hex_q       <= hex_d;
      le_q        <= le_d;
      pt_q        <= pt_d;
      an_q        <= an_d;
    end
  end

  assign hex     = hex_q;
  assign le      = le_q;
  assign pt      = pt_q;
  assign an      = an_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux at DIV_W=2 (tick every 4 clocks, frame every 16).
module tb_disp_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  hex;
  logic        le;
  logic        pt;
  logic [3:0]  an;
  logic        pending;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  disp_scan_mux #(
    .DIV_W (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data    (data),
    .dp      (dp),
    .blank   (blank),
    .hex     (hex),
    .le      (le),
    .pt      (pt),
    .an      (an),
    .pending (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  le_plain;
    logic [3:0]  le_lzb;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_until(input int phase);
    int guard = 0;
    while ((cyc % 16) != phase && guard < 32) begin
      step();
      guard++;
    end
    chk("wait_bound", (guard < 32) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_digit(input string tag, input int k, input logic [3:0] exp_hex,
                             input logic exp_le, input logic exp_pt);
    logic [3:0] exp_an;
    exp_an    = 4'hF;
    exp_an[k] = 1'b0;
    chk({tag, "_an"}, 32'(an), 32'(exp_an));
    chk({tag, "_hex"}, 32'(hex), 32'(exp_hex));
    chk({tag, "_le"}, 32'(le), 32'(exp_le));
    chk({tag, "_pt"}, 32'(pt), 32'(exp_pt));
  endtask

  initial begin
    logic [3:0] le_exp;

    vecs[0] = '{data: 16'h12AB, dp: 4'b0100, blank: 4'b0000, le_plain: 4'b0000, le_lzb: 4'b0000};
    vecs[1] = '{data: 16'h0050, dp: 4'b0000, blank: 4'b0000, le_plain: 4'b0000, le_lzb: 4'b1100};
    vecs[2] = '{data: 16'h0000, dp: 4'b1001, blank: 4'b1010, le_plain: 4'b1010, le_lzb: 4'b1110};
    vecs[3] = '{data: 16'hF00E, dp: 4'b0011, blank: 4'b0001, le_plain: 4'b0001, le_lzb: 4'b0001};

    rst   = 1'b1;
    load  = 1'b0;
    data  = '0;
    dp    = '0;
    blank = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_hex", 32'(hex), 32'h0);
    chk("rst_le", 32'(le), 32'h1);
    chk("rst_pt", 32'(pt), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    rst = 1'b0;
    cyc = 0;

    repeat (3) step();
    chk("pre_tick_an", 32'(an), 32'hF);
    step();
    check_digit("first_tick", 0, 4'h0, 1'b1, 1'b0);

    // Mid-frame load, then the following frame shows it.
    for (int v = 0; v < 4; v++) begin
      data  = vecs[v].data;
      dp    = vecs[v].dp;
      blank = vecs[v].blank;
      load  = 1'b1;
      step();
      load  = 1'b0;
      chk("tbl_pending_set", 32'(pending), 32'h1);
      step_until(4);
`ifdef DISP_LZB_EN
      le_exp = vecs[v].le_lzb;
`else
      le_exp = vecs[v].le_plain;
`endif
      chk("tbl_pending_clr", 32'(pending), 32'h0);
      for (int k = 0; k < 4; k++) begin
        if (k != 0) repeat (4) step();
        check_digit($sformatf("tbl%0d_d%0d", v, k), k, vecs[v].data[4*k +: 4], le_exp[k],
                    vecs[v].dp[k]);
      end
    end

    // Load exactly on the frame-boundary edge goes straight to the display.
    step_until(3);
    data  = 16'h00F0;
    dp    = 4'b0000;
    blank = 4'b0000;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check_digit("bnd_d0", 0, 4'h0, 1'b0, 1'b0);
    chk("bnd_pending", 32'(pending), 32'h0);
    repeat (4) step();
    check_digit("bnd_d1", 1, 4'hF, 1'b0, 1'b0);

    // Two loads in one frame: old frame keeps showing, only the last load appears.
    data = 16'h1111;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("two_pending1", 32'(pending), 32'h1);
    chk("two_notear_d1", 32'(hex), 32'hF);
    repeat (3) step();
`ifdef DISP_LZB_EN
    check_digit("two_notear_d2", 2, 4'h0, 1'b1, 1'b0);
`else
    check_digit("two_notear_d2", 2, 4'h0, 1'b0, 1'b0);
`endif
    data = 16'h2222;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("two_pending2", 32'(pending), 32'h1);
    step_until(4);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) repeat (4) step();
      check_digit($sformatf("two_d%0d", k), k, 4'h2, 1'b0, 1'b0);
    end

    // Reset mid-frame with a capture pending: pending data must never show.
    data = 16'h3333;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("mid_rst_pending_pre", 32'(pending), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_hex", 32'(hex), 32'h0);
    chk("mid_rst_le", 32'(le), 32'h1);
    chk("mid_rst_pt", 32'(pt), 32'h0);
    chk("mid_rst_pending", 32'(pending), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    repeat (4) step();
    check_digit("post_rst_d0", 0, 4'h0, 1'b1, 1'b0);
    chk("post_rst_pending", 32'(pending), 32'h0);
    repeat (4) step();
    check_digit("post_rst_d1", 1, 4'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
